// File: rtl/delay_timer_mc_if.sv
// Bundle of the control inputs and status outputs of the multi-channel
// delay timer. The master side programs the channels; the slave side is the
// timer itself.
interface delay_timer_mc_if #(
  parameter int CHANNELS  = 4,
  parameter int DLY_WIDTH = 16
);
  logic [CHANNELS-1:0]           enable;
  logic [CHANNELS*DLY_WIDTH-1:0] delay_us;
  logic [CHANNELS*2-1:0]         mode;
  logic [CHANNELS-1:0]           done;
  logic [CHANNELS-1:0]           done_pulse;
  logic [CHANNELS-1:0]           busy;

  modport master (
    output enable, delay_us, mode,
    input  done, done_pulse, busy
  );

  modport slave (
    input  enable, delay_us, mode,
    output done, done_pulse, busy
  );
endinterface

// File: rtl/delay_timer_mc.sv
// Multi-channel programmable delay timer. Each channel counts
// max(D,1)*FREQ_MHZ clock edges after a rising edge of its enable and then
// flags expiry in level, one-shot pulse, or periodic mode. All outputs are
// registered.
module delay_timer_mc #(
  parameter int FREQ_MHZ  = 50,
  parameter int CHANNELS  = 4,
  parameter int DLY_WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  delay_timer_mc_if.slave bus
);

  // A 1 MHz clock still needs a 1-bit prescaler so the vector is legal.
  localparam int             PW       = (FREQ_MHZ > 1) ? $clog2(FREQ_MHZ) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(FREQ_MHZ - 1);
  localparam logic [1:0]     MODE_PER = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_EXPIRED = 2'd2
  } state_e;

  logic [CHANNELS-1:0] done_vec;
  logic [CHANNELS-1:0] pulse_vec;
  logic [CHANNELS-1:0] busy_vec;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    state_e                 state_q, state_d;
    logic [PW-1:0]          pre_q, pre_d;
    logic [DLY_WIDTH-1:0]   us_q, us_d;
    logic [DLY_WIDTH-1:0]   dly_q, dly_d;
    logic                   per_q, per_d;
    logic                   en_q;
    logic                   done_q, done_d;
    logic                   pulse_q, pulse_d;
    logic                   busy_q, busy_d;

    logic                   en_in;
    logic [DLY_WIDTH-1:0]   dly_in;
    logic [1:0]             mode_in;
    logic                   rise;
    logic                   step;
    logic                   expire;
    logic [PW-1:0]          base_pre;
    logic [DLY_WIDTH-1:0]   base_us;
    logic [DLY_WIDTH-1:0]   dly_eff;

    assign en_in   = bus.enable[ch];
    assign dly_in  = bus.delay_us[ch*DLY_WIDTH +: DLY_WIDTH];
    assign mode_in = bus.mode[ch*2 +: 2];
    assign rise    = en_in && !en_q;

    // State register: FSM state, counters, latches and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= ST_IDLE;
        pre_q   <= '0;
        us_q    <= '0;
        dly_q   <= '0;
        per_q   <= 1'b0;
        // NOTE: previous-enable resets high, so an enable held through reset
        // is not mistaken for a rising edge; the channel waits for a toggle.
        en_q    <= 1'b1;
        done_q  <= 1'b0;
        pulse_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments so every flop samples the values
        // computed before this edge, independent of statement order.
        state_q <= state_d;
        pre_q   <= pre_d;
        us_q    <= us_d;
        dly_q   <= dly_d;
        per_q   <= per_d;
        en_q    <= en_in;
        done_q  <= done_d;
        pulse_q <= pulse_d;
        busy_q  <= busy_d;
      end
    end

    // Next-state logic: start on enable rise, advance the prescaler/us
    // counters, detect expiry and reload in periodic mode.
    always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      state_d  = state_q;
      pre_d    = pre_q;
      us_d     = us_q;
      dly_d    = dly_q;
      per_d    = per_q;
      step     = 1'b0;
      expire   = 1'b0;
      base_pre = pre_q;
      base_us  = us_q;
      dly_eff  = (dly_q == '0) ? DLY_WIDTH'(1) : dly_q;

      if (!en_in) begin
        // Dropping enable wins over everything, including a coincident expiry.
        state_d = ST_IDLE;
        pre_d   = '0;
        us_d    = '0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (rise) begin
              // The start edge is itself count 1: step from a zero base using
              // the freshly sampled delay and mode.
              step     = 1'b1;
              base_pre = '0;
              base_us  = '0;
              dly_d    = dly_in;
              per_d    = (mode_in == MODE_PER);
              dly_eff  = (dly_in == '0) ? DLY_WIDTH'(1) : dly_in;
              state_d  = ST_COUNT;
            end
          end
          ST_COUNT:   step = 1'b1;
          ST_EXPIRED: step = 1'b0;
          default:    state_d = ST_IDLE;
        endcase

        if (step) begin
          if (base_pre == PRE_LAST) begin
            pre_d = '0;
            if (base_us == dly_eff - 1'b1) begin
              expire = 1'b1;
              if (per_d) begin
                // Periodic: restart from zero with a re-sampled delay.
                us_d    = '0;
                dly_d   = dly_in;
                state_d = ST_COUNT;
              end else begin
                us_d    = dly_eff;
                state_d = ST_EXPIRED;
              end
            end else begin
              us_d = base_us + 1'b1;
            end
          end else begin
            pre_d = base_pre + 1'b1;
            us_d  = base_us;
          end
        end
      end
    end

    // Output logic: values the output flops take at this edge.
    always_comb begin
      busy_d  = (state_d == ST_COUNT);
      pulse_d = expire;
      done_d  = en_in && (done_q || expire);
    end

    assign done_vec[ch]  = done_q;
    assign pulse_vec[ch] = pulse_q;
    assign busy_vec[ch]  = busy_q;
  end

  assign bus.done       = done_vec;
  assign bus.done_pulse = pulse_vec;
  assign bus.busy       = busy_vec;

endmodule
